// File: rtl/tim_pkg.sv
// Shared types and default widths for the TIM timer family.
// Used by the input-capture channel and its input filter.
package tim_pkg;

    localparam int CNT_W_DEF  = 16;
    localparam int FILT_W_DEF = 4;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_OFF  = 2'b11
    } edge_sel_e;

endpackage

// File: rtl/tim_in_filter.sv
// Capture pin conditioning: two-flop synchroniser, stable-count glitch filter
// and edge detector. Runs regardless of the timer enable.
module tim_in_filter
    import tim_pkg::*;
#(
    parameter int FILT_W = FILT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cap_in,
    input  logic [FILT_W-1:0] filt,
    input  logic [1:0]        edge_sel,
    output logic              edge_det
);

    logic              sync1;
    logic              sync2;
    logic              level;
    logic              level_d;
    logic [FILT_W-1:0] stab_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            level    <= 1'b0;
            level_d  <= 1'b0;
            stab_cnt <= '0;
        end else begin
            sync1   <= cap_in;
            sync2   <= sync1;
            level_d <= level;
            // A sample equal to the accepted level restarts the stability run.
            if (sync2 == level) begin
                stab_cnt <= '0;
            end else if (stab_cnt == filt) begin
                level    <= sync2;
                stab_cnt <= '0;
            end else begin
                stab_cnt <= stab_cnt + FILT_W'(1);
            end
        end
    end

    // Decoded from registered state only, so the pulse is exactly one cycle.
    always_comb begin
        edge_det = 1'b0;
        case (edge_sel_e'(edge_sel))
            EDGE_RISE: edge_det = level & ~level_d;
            EDGE_FALL: edge_det = ~level & level_d;
            EDGE_BOTH: edge_det = level ^ level_d;
            default:   edge_det = 1'b0;
        endcase
    end

endmodule

// File: rtl/tim_capture.sv
// Input-capture timer channel: prescaled free-running counter that is
// time-stamped into cap_val on a filtered, selected edge of cap_in.
module tim_capture
    import tim_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int FILT_W = FILT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              cap_in,
    input  logic [1:0]        edge_sel,
    input  logic [CNT_W-1:0]  psc,
    input  logic [FILT_W-1:0] filt,
    input  logic              cnt_clr,
    input  logic              cap_ack,
    output logic [CNT_W-1:0]  cnt,
    output logic [CNT_W-1:0]  cap_val,
    output logic              cap_valid,
    output logic              overcapture,
    output logic              cap_irq,
    output logic              ovf_irq
);

    logic [CNT_W-1:0] psc_cnt;
    logic             tick;
    logic             edge_det;
    logic             cap_evt;

    tim_in_filter #(
        .FILT_W (FILT_W)
    ) u_in_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .cap_in   (cap_in),
        .filt     (filt),
        .edge_sel (edge_sel),
        .edge_det (edge_det)
    );

    assign tick    = en && (psc_cnt == psc);
    assign cap_evt = en && edge_det;

    // psc_cnt above psc (psc lowered while running) snaps back to 0 without a tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_cnt <= '0;
            cnt     <= '0;
            ovf_irq <= 1'b0;
        end else begin
            ovf_irq <= 1'b0;
            if (cnt_clr) begin
                psc_cnt <= '0;
                cnt     <= '0;
            end else if (en) begin
                if (psc_cnt >= psc) begin
                    psc_cnt <= '0;
                end else begin
                    psc_cnt <= psc_cnt + CNT_W'(1);
                end
                if (tick) begin
                    cnt     <= cnt + CNT_W'(1);
                    ovf_irq <= (cnt == '1);
                end
            end
        end
    end

    // cap_valid/cap_ack handshake: cap_valid rises on a capture and holds until
    // a cycle with cap_ack high and no new capture; a capture in the ack cycle
    // wins and re-arms cap_valid with overcapture cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_val     <= '0;
            cap_valid   <= 1'b0;
            overcapture <= 1'b0;
            cap_irq     <= 1'b0;
        end else begin
            cap_irq <= cap_evt;
            if (cap_evt) begin
                cap_val     <= cnt;
                cap_valid   <= 1'b1;
                overcapture <= cap_valid && !cap_ack;
            end else if (cap_ack) begin
                cap_valid   <= 1'b0;
                overcapture <= 1'b0;
            end
        end
    end

endmodule
